// File: rtl/registro_universal_oe.sv
// Universal WIDTH-bit holding register: parallel load, single-step shifts and a START/SHAMT shift sequencer.
// Latency: load/step ops land on the next clk edge; a START of k steps shifts on edges t+1..t+k, DONE in the cycle after t+k.
// Backpressure: BUSY=1 while sequencing; EN/MODE/D/START/SHAMT are ignored until the sequencer returns to IDLE.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   EN, MODE      single-cycle op enable; MODE 00 hold, 01 load, 10 shift right, 11 shift left
//   D             parallel load data
//   SIN_R, SIN_L  serial inputs entering the MSB (right shift) / LSB (left shift)
//   START, SHAMT  multi-step shift request (direction from MODE[0], MODE[1] must be 1) and step count
//   OE            output enable for Q
//   Q             register contents when OE=1, high-Z otherwise
//   SOUT_R/SOUT_L R[0] / R[WIDTH-1], always driven
//   BUSY, DONE    sequencer active / one-cycle completion pulse
module registro_universal_oe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_R,
  input  logic             SIN_L,
  input  logic             START,
  input  logic [SHW-1:0]   SHAMT,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [SHW-1:0] WIDTH_S = SHW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 1 = left, 0 = right
  logic             done_q, done_d;

  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

  assign shr_val = {SIN_R, r_q[WIDTH-1:1]};
  assign shl_val = {r_q[WIDTH-2:0], SIN_L};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A shift-mode START outranks EN; a START with MODE=0x falls through to the EN rules.
        if (START && MODE[1]) begin
          if (SHAMT == '0) begin
            done_d = 1'b1;
          end else begin
            // Counts beyond WIDTH saturate: the word is fully replaced by serial input anyway.
            cnt_d   = (SHAMT > WIDTH_S) ? WIDTH_S : SHAMT;
            dir_d   = MODE[0];
            state_d = SHIFT;
          end
        end else if (EN) begin
          case (MODE)
            2'b01:   r_d = D;
            2'b10:   r_d = shr_val;
            2'b11:   r_d = shl_val;
            default: r_d = r_q;
          endcase
        end
      end

      SHIFT: begin
        r_d   = dir_q ? shl_val : shr_val;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign Q      = OE ? r_q : {WIDTH{1'bz}};
  assign SOUT_R = r_q[0];
  assign SOUT_L = r_q[WIDTH-1];
  assign BUSY   = (state_q == SHIFT);
  assign DONE   = done_q;

endmodule

// File: doc/registro_universal_oe.md
Name: registro_universal_oe

Overview:
- Parametrised successor to the 4-bit D register with EN/OE.
- Holds a WIDTH-bit word with parallel load, single-step shifting and an automatic multi-bit shift sequencer (BUSY/DONE handshake).
- Parallel output is tri-stated by OE; serial outputs are always driven.
- Sits on a shared data bus as a loadable/shiftable data holding stage.

Parameters:
- WIDTH, 8: register width in bits (≥2).
- SHW, $clog2(WIDTH)+1 (localparam): width of SHAMT and the internal shift counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- EN  input  1  enables the single-cycle operation selected by MODE.
- MODE  input  2  00 hold, 01 parallel load, 10 shift right, 11 shift left.
- D  input  WIDTH  parallel load data.
- SIN_R  input  1  serial input entering the MSB on right shifts.
- SIN_L  input  1  serial input entering the LSB on left shifts.
- START  input  1  starts a multi-bit shift (direction from MODE 10/11).
- SHAMT  input  SHW  number of shift steps for START.
- OE  input  1  output enable for Q.
- Q  output  WIDTH  register contents when OE=1, high-Z when OE=0.
- SOUT_R  output  1  R[0], always driven.
- SOUT_L  output  1  R[WIDTH-1], always driven.
- BUSY  output  1  high while the sequencer is shifting.
- DONE  output  1  one-cycle pulse when a START sequence completes.

Behaviour:
- Internal state: register R, counter CNT (SHW bits), and a two-state FSM {IDLE, SHIFT}.
- Reset (rst=1 at a clk edge) has top priority:
  - R=0, CNT=0, state IDLE, BUSY=0, DONE=0.
  - Q still follows OE (reads 0 when OE=1, Z when OE=0).
- Q is combinational: Q = OE ? R : 'z. OE affects no internal state.
- SOUT_R/SOUT_L are combinational from R and never tri-stated.
- IDLE, START=1 with MODE=1x (multi-shift has priority over EN):
  - SHAMT=0: R unchanged, stay IDLE, DONE=1 next cycle, BUSY stays 0.
  - SHAMT>0: CNT=min(SHAMT,WIDTH), direction latched from MODE[0], go to SHIFT, BUSY=1 next cycle. No shift on the START edge.
- IDLE, START=1 with MODE=0x: START is ignored and EN rules apply.
- IDLE, EN=1, no valid START: one operation per edge.
  - 00: hold.
  - 01: R=D.
  - 10: R={SIN_R, R[WIDTH-1:1]}.
  - 11: R={R[WIDTH-2:0], SIN_L}.
- IDLE, EN=0: hold.
- SHIFT state:
  - Each edge performs one shift in the latched direction, sampling SIN_R/SIN_L on that edge, and sets CNT=CNT-1.
  - When CNT=1 at the edge, the final shift occurs, the FSM returns to IDLE, and DONE=1 for exactly the following cycle. BUSY falls in that same cycle.
  - EN, MODE, D, START and SHAMT are ignored while BUSY=1. A START held high across completion is ignored on the DONE cycle edge, since the FSM is still finishing.
- Latency: START at edge t with SHAMT=k (1≤k≤WIDTH):
  - Shifts occur at edges t+1 … t+k.
  - BUSY is high from t+1 to t+k.
  - DONE is high between edges t+k and t+k+1.
- Saturation: SHAMT>WIDTH is treated as WIDTH; the result is all serial-input bits.
- rst during SHIFT: aborts the sequence and returns to IDLE with R=0; DONE is not asserted.
- Earliest restart: a new START is accepted on the edge ending the DONE cycle.

Test Plan:
- Reset/OE (WIDTH=8): rst=1 one edge, OE=1 → Q=00000000, BUSY=0, DONE=0. OE=0 → Q=zzzzzzzz.
- Load/hold: EN=1, MODE=01, D=10100101, then EN=0 with D=11111111 → Q stays 10100101. With OE=0 during the load, raising OE later → Q=10100101.
- Single steps: R=10100101, EN=1, MODE=10, SIN_R=1 → 11010010. Then MODE=11, SIN_L=0 → 10100100. SOUT_R/SOUT_L match R[0]/R[7].
- Multi-shift: R=10000001, START=1, MODE=11, SHAMT=3, SIN_L=1 → BUSY high 3 cycles, R=00001111, then DONE high exactly 1 cycle. EN/D toggled during BUSY cause no effect.
- Boundaries: SHAMT=0 → DONE pulse with no BUSY and R unchanged. SHAMT=15 with MODE=10 and SIN_R=0 → 8 shifts, R=00000000, DONE once.
- Reset mid-sequence: START with SHAMT=6, assert rst at the 2nd BUSY cycle → R=0, BUSY=0 next cycle, no DONE pulse. A subsequent load works normally.
